// File: rtl/depthwise_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : depthwise_weight_loader
//  Purpose  : Upstream feeder for the depthwise 3x3 kernel register bank.
//             Accepts packed weight words over a valid/ready stream and
//             unpacks each word into single-weight writes. Write addresses
//             run sequentially from 0 to CHANNELS*9-1 (channel-major, nine
//             taps per channel). Completion and length errors are reported
//             to the layer controller.
//  Ports    : clk, reset     - clock, synchronous active-high reset
//             start          - one-cycle pulse, begins a full kernel load
//             s_valid/s_ready/s_data/s_last - packed weight stream (lane 0
//                              in s_data[DATA_W-1:0] is written first)
//             wr_en/wr_addr/wr_data - kernel bank write port
//             busy           - load in progress
//             done           - one-cycle completion pulse
//             err_len        - sticky s_last/length mismatch flag, cleared by
//                              the next accepted start
//  Revision : 1.0 - initial release
// ============================================================================
module depthwise_weight_loader #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 32,
    parameter int BUS_W    = 32,
    localparam int ADDR_W  = $clog2(CHANNELS * 9)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BUS_W-1:0]         s_data,
    input  logic                     s_last,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len
);

    localparam int LANES  = BUS_W / DATA_W;
    localparam int TOTAL  = CHANNELS * 9;
    localparam int NWORDS = (TOTAL + LANES - 1) / LANES;
    localparam int TAIL   = TOTAL - (NWORDS - 1) * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [LANE_W-1:0] c_lane_full  = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] c_lane_tail  = LANE_W'(TAIL - 1);
    localparam logic [WORD_W-1:0] c_word_final = WORD_W'(NWORDS - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_unpack = 2'd2;
    localparam logic [1:0] c_st_finish = 2'd3;

    logic [1:0]               r_state;
    logic                     r_s_ready;
    logic                     r_wr_en;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic signed [DATA_W-1:0] r_wr_data;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err_len;

    logic [ADDR_W-1:0]        r_wcnt;       // next weight address
    logic [WORD_W-1:0]        r_word;       // index of the current word
    logic [LANE_W-1:0]        r_lane;       // lane being written
    logic [LANE_W-1:0]        r_lane_last;  // last lane to write in this word
    logic [BUS_W-1:0]         r_data;       // latched word, shifted per lane
    logic                     r_last;       // latched s_last
    logic                     r_final;      // current word is word NWORDS-1

    logic                     w_word_is_final;

    assign w_word_is_final = (r_word == c_word_final);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_s_ready   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_wcnt      <= '0;
            r_word      <= '0;
            r_lane      <= '0;
            r_lane_last <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_final     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // r_done is high in the cycle right after FINISH; a start
                    // coinciding with that pulse is deliberately ignored.
                    if (start && !r_done) begin
                        r_state   <= c_st_wait;
                        r_busy    <= 1'b1;
                        r_s_ready <= 1'b1;
                        r_wcnt    <= '0;
                        r_word    <= '0;
                        r_err_len <= 1'b0;
                    end
                end
                c_st_wait: begin
                    if (s_valid && r_s_ready) begin
                        r_data      <= s_data;
                        r_last      <= s_last;
                        r_final     <= w_word_is_final;
                        r_lane      <= '0;
                        r_lane_last <= w_word_is_final ? c_lane_tail : c_lane_full;
                        r_s_ready   <= 1'b0;
                        r_state     <= c_st_unpack;
                        // Early s_last, or a missing s_last on the final word.
                        if (s_last != w_word_is_final) begin
                            r_err_len <= 1'b1;
                        end
                    end
                end
                c_st_unpack: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wcnt;
                    r_wr_data <= r_data[DATA_W-1:0];
                    r_data    <= r_data >> DATA_W;
                    r_wcnt    <= r_wcnt + ADDR_W'(1);
                    r_lane    <= r_lane + LANE_W'(1);
                    if (r_lane == r_lane_last) begin
                        if (r_final || r_last) begin
                            r_state <= c_st_finish;
                        end else begin
                            r_word    <= r_word + WORD_W'(1);
                            r_s_ready <= 1'b1;
                            r_state   <= c_st_wait;
                        end
                    end
                end
                c_st_finish: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_len = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_depthwise_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_depthwise_weight_loader
//  Purpose  : Self-checking bench for depthwise_weight_loader. A default
//             instance is driven with randomised loads; expected writes are
//             queued when words are issued and a monitor pops and compares
//             them. A second small instance (CHANNELS=3) covers the partial
//             final word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_depthwise_weight_loader;

    localparam int LANES  = 4;
    localparam int TOTAL  = 288;
    localparam int NWORDS = 72;

    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_ready, s_last;
    logic        wr_en, busy, done, err_len;
    logic [31:0] s_data;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;

    logic        start3, s_valid3, s_ready3, s_last3;
    logic        wr_en3, busy3, done3, err3;
    logic [31:0] s_data3;
    logic [4:0]  wr_addr3;
    logic [7:0]  wr_data3;

    always #5 clk = ~clk;

    depthwise_weight_loader #(.DATA_W(8), .CHANNELS(32), .BUS_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .err_len(err_len)
    );

    depthwise_weight_loader #(.DATA_W(8), .CHANNELS(3), .BUS_W(32)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .s_valid(s_valid3),
        .s_ready(s_ready3), .s_data(s_data3), .s_last(s_last3), .wr_en(wr_en3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .busy(busy3), .done(done3),
        .err_len(err3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int exp_addr_q[$];
    int exp_data_q[$];
    bit exp_err = 1'b0;
    int last_wr_cyc = 0;
    bit done_prev = 1'b0;
    int mon_a, mon_d;

    logic [7:0] mem3 [0:31];
    int         wcount3 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk("write_without_expectation", 64'(wr_addr), 64'hFFFF);
                end else begin
                    mon_a = exp_addr_q.pop_front();
                    mon_d = exp_data_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mon_a));
                    chk("wr_data", 64'(wr_data), 64'(mon_d));
                end
                last_wr_cyc = cyc;
            end
            if (s_ready) chk("s_ready_outside_load", 64'({busy, done}), 64'b10);
            if (done) begin
                chk("done_all_writes_seen", 64'(exp_addr_q.size()), 64'd0);
                chk("err_len_at_done", 64'(err_len), 64'(exp_err));
                chk("done_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
                chk("busy_low_with_done", 64'(busy), 64'd0);
                if (done_prev) chk("done_single_cycle", 64'd1, 64'd0);
            end
            done_prev = done;
        end
    end

    always @(negedge clk) begin
        if (!reset && wr_en3) begin
            chk("dut3_addr_in_range", 64'(wr_addr3 <= 5'd26), 64'd1);
            mem3[wr_addr3] = wr_data3;
            wcount3++;
        end
    end

    // Issue one load. Words past last_word are never sent; last_word >= NWORDS
    // means s_last is never asserted. mid_start_word pulses start while that
    // word is presented; reset_word aborts the load during that word's unpack.
    task automatic run_load(input int last_word, input bit gaps, input bit patterned,
                            input int mid_start_word, input int reset_word,
                            output int hs0_cyc, output int done_cyc);
        int nsend;
        int budget;
        bit hs;
        logic [31:0] w;
        hs0_cyc  = 0;
        done_cyc = 0;
        nsend    = (last_word < NWORDS) ? last_word + 1 : NWORDS;
        exp_err  = (last_word != NWORDS - 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_len_cleared_by_start", 64'(err_len), 64'd0);
        for (int k = 0; k < nsend; k++) begin
            if (patterned)
                w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            else
                w = $urandom;
            for (int j = 0; j < LANES; j++) begin
                if (k * LANES + j < TOTAL) begin
                    exp_addr_q.push_back(k * LANES + j);
                    exp_data_q.push_back(int'((w >> (8 * j)) & 32'hFF));
                end
            end
            s_data = w;
            s_last = (k == last_word);
            hs     = 1'b0;
            budget = 0;
            while (!hs) begin
                s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                start   = (k == mid_start_word) && (budget == 0);
                hs      = s_valid && s_ready;
                if (hs && k == 0) hs0_cyc = cyc;
                @(negedge clk);
                budget++;
                if (!hs && budget > 100) begin
                    chk("handshake_timeout", 64'd1, 64'd0);
                    s_valid = 1'b0;
                    start   = 1'b0;
                    return;
                end
            end
            start = 1'b0;
            if (k == reset_word) begin
                @(negedge clk);
                reset   = 1'b1;
                s_valid = 1'b0;
                @(negedge clk);
                chk("wr_en_after_reset", 64'(wr_en), 64'd0);
                chk("busy_after_reset", 64'(busy), 64'd0);
                exp_addr_q.delete();
                exp_data_q.delete();
                reset = 1'b0;
                return;
            end
        end
        // Keep junk valid on the stream: it must not be consumed.
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'b0;
        budget  = 0;
        while (!done) begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                chk("done_timeout", 64'd1, 64'd0);
                s_valid = 1'b0;
                return;
            end
        end
        done_cyc = cyc;
        start = 1'b1;                   // coincides with the done pulse
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        chk("start_with_done_ignored", 64'(busy), 64'd0);
    endtask

    int hs0, dc, budget3;
    bit hs3;
    logic [31:0] w3 [0:6];

    initial begin
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        start3 = 1'b0; s_valid3 = 1'b0; s_data3 = '0; s_last3 = 1'b0;
        for (int i = 0; i < 32; i++) mem3[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", 64'(s_ready), 64'd0);
        chk("reset_wr_en",   64'(wr_en),   64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_busy",    64'(busy),    64'd0);
        chk("reset_done",    64'(done),    64'd0);
        chk("reset_err_len", 64'(err_len), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full patterned load, gap-free.
        run_load(71, 1'b0, 1'b1, -1, -1, hs0, dc);
        chk("full_load_latency", 64'(dc - hs0), 64'd361);
        // Early termination on word 10.
        run_load(10, 1'b0, 0, -1, -1, hs0, dc);
        // Same patterned load with random valid gaps; start clears err_len.
        run_load(71, 1'b1, 1'b1, -1, -1, hs0, dc);
        // start pulsed mid-load at word 5 is ignored.
        run_load(71, 1'b0, 1'b0, 5, -1, hs0, dc);
        chk("mid_start_latency", 64'(dc - hs0), 64'd361);
        // Reset during unpack of word 3, then a fresh load from address 0.
        run_load(71, 1'b0, 1'b0, -1, 3, hs0, dc);
        run_load(71, 1'b1, 1'b0, -1, -1, hs0, dc);
        // No s_last on the final word.
        run_load(1000, 1'b1, 1'b0, -1, -1, hs0, dc);

        // Small instance: 27 weights, partial final word.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            w3[k]    = (k == 6) ? 32'hDDCCBBAA : $urandom;
            s_data3  = w3[k];
            s_last3  = (k == 6);
            s_valid3 = 1'b1;
            hs3      = 1'b0;
            budget3  = 0;
            while (!hs3 && budget3 <= 100) begin
                hs3 = s_ready3;
                @(negedge clk);
                budget3++;
            end
            if (!hs3) chk("dut3_handshake_timeout", 64'd1, 64'd0);
        end
        s_valid3 = 1'b0;
        budget3  = 0;
        while (!done3 && budget3 <= 100) begin
            @(negedge clk);
            budget3++;
        end
        chk("dut3_done", 64'(done3), 64'd1);
        chk("dut3_err_len", 64'(err3), 64'd0);
        chk("dut3_write_count", 64'(wcount3), 64'd27);
        for (int i = 0; i < 27; i++)
            chk("dut3_data", 64'(mem3[i]), 64'((w3[i / 4] >> (8 * (i % 4))) & 32'hFF));
        chk("dut3_addr26", 64'(mem3[26]), 64'hCC);
        chk("dut3_no_dd_write", 64'(mem3[27]), 64'h00);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/depthwise_weight_loader.md
Name: depthwise_weight_loader

Overview:
Upstream feeder for the depthwise 3x3 kernel register bank. It accepts packed weight words over a valid/ready stream, typically from the DMA/weight FIFO. It unpacks each word into single-weight writes (wr_en/wr_addr/wr_data) that drive the kernel bank's write port. Addresses run sequentially from 0 to CHANNELS*9-1 (channel-major, 9 taps per channel), and the block reports completion and length errors to the layer controller.

Parameters:
DATA_W, 8, width of one signed weight
CHANNELS, 32, depthwise channels; total weights TOTAL = CHANNELS*9
BUS_W, 32, stream word width; must be an integer multiple of DATA_W; LANES = BUS_W/DATA_W
(derived) ADDR_W = $clog2(CHANNELS*9); NWORDS = ceil(TOTAL/LANES); TAIL = TOTAL - (NWORDS-1)*LANES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a full kernel load
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  BUS_W  packed weights; lane 0 = s_data[DATA_W-1:0] is written first
s_last  in  1  marks the final word of the load
wr_en  out  1  kernel bank write strobe
wr_addr  out  ADDR_W  kernel bank write address
wr_data  out  DATA_W  signed weight
busy  out  1  load in progress
done  out  1  one-cycle completion pulse
err_len  out  1  sticky s_last/length mismatch flag; cleared by the next accepted start

Behaviour:
- Reset values (clk is the clock; reset is synchronous, active-high): state IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err_len=0, weight counter=0, word counter=0.
- All outputs are registered.
- FSM states: IDLE, WAIT_WORD, UNPACK, FINISH.
- IDLE:
  - start=1 -> WAIT_WORD; busy=1, counters=0, err_len=0.
  - s_ready=0 in IDLE.
- WAIT_WORD:
  - s_ready=1.
  - On s_valid&&s_ready: latch s_data and s_last, lane=0, go to UNPACK. s_ready drops the next cycle.
  - No write occurs in the handshake cycle.
- UNPACK, one weight per cycle:
  - wr_en=1, wr_addr=weight counter, wr_data=lane slice.
  - Lane and weight counter increment each cycle.
  - Word accepted at edge T -> writes visible in cycles T+1 .. T+n, where n = LANES, or TAIL for word NWORDS-1.
  - Lanes beyond TAIL in the final word are discarded and never written.
- End of word:
  - If the word was word NWORDS-1, or the latched s_last=1 -> FINISH.
  - Otherwise -> WAIT_WORD.
- Length check (either case sets err_len=1):
  - s_last=1 on a word other than NWORDS-1: early termination. The current word is still fully unpacked, then FINISH; remaining addresses keep their prior contents.
  - s_last=0 on word NWORDS-1: the load still completes normally.
- FINISH: wr_en=0, done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Addresses never exceed TOTAL-1 and never wrap.
- start while busy=1 is ignored, with no counter reset.
- start in the same cycle as the FINISH pulse is ignored. It is accepted from IDLE on the next cycle.
- s_valid while in IDLE/UNPACK/FINISH is not consumed, because s_ready=0.
- Reset mid-load:
  - Next cycle: wr_en=0, state IDLE, no further writes.
  - Kernel bank contents already written are not this block's concern.
- Throughput: LANES+1 cycles per full word. A full default load (72 words) takes 360 cycles from the first handshake to done, given s_valid held high.

Test Plan:
- Defaults; start, then 72 words with s_valid always 1, word k = {4k+3,4k+2,4k+1,4k}, s_last on word 71 -> 288 writes, addr i carries data i&0xFF, done pulses once 1 cycle after the addr-287 write, err_len=0.
- CHANNELS=3, BUS_W=32 (TOTAL=27, NWORDS=7, TAIL=3); word 6 = 0xDDCCBBAA with s_last -> final writes addr 24=0xAA, 25=0xBB, 26=0xCC; 0xDD is never written; done asserted, err_len=0.
- Defaults; s_last asserted on word 10 -> writes for addr 0..43 only, then done, err_len=1. A following start clears err_len.
- Random s_valid gaps (about 50% duty) -> identical write sequence to the gap-free run; s_ready is high only in WAIT_WORD; no word is dropped or duplicated.
- start pulsed at word 5 mid-load -> ignored, address sequence continues at 20+.
- reset asserted during UNPACK of word 3 -> wr_en=0 and busy=0 the next cycle; a fresh start restarts at addr 0.
- Boundary: s_last=0 on word 71 -> all 288 writes, done asserted, err_len=1.
